// File: rtl/cam_capture_ds_if.sv
// -----------------------------------------------------------------------------
// cam_capture_ds_if
// Bundles the OV7670 pixel bus, the frame-buffer write port and the capture
// status lines of cam_capture_ds.
//   slave  : the capture block (consumes camera bus, drives write port/status)
//   master : the camera / frame-buffer side (drives camera bus, observes rest)
// Signals:
//   vsync, href, data[7:0], mode[1:0]        camera side
//   w_addr[ADDR_W-1:0], w_data[7:0], w_en    frame-buffer write port
//   frame_done, frame_count[7:0], clip, line_err   status
// -----------------------------------------------------------------------------
interface cam_capture_ds_if #(
  parameter int ADDR_W = 15
) ();
  logic              vsync;
  logic              href;
  logic [7:0]        data;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              w_en;
  logic              frame_done;
  logic [7:0]        frame_count;
  logic              clip;
  logic              line_err;

  modport master (
    output vsync, href, data, mode,
    input  w_addr, w_data, w_en, frame_done, frame_count, clip, line_err
  );

  modport slave (
    input  vsync, href, data, mode,
    output w_addr, w_data, w_en, frame_done, frame_count, clip, line_err
  );
endinterface

// File: rtl/cam_capture_ds.sv
// -----------------------------------------------------------------------------
// cam_capture_ds
// OV7670 capture and downsampler. Runs entirely in the camera PCLK domain.
// Tracks VSYNC/HREF, assembles two-byte pixels in one of four formats,
// converts them to RGB332, optionally decimates 2:1 in both directions and
// writes them into a SCREEN_WIDTH x SCREEN_HEIGHT frame buffer.
// Ports:
//   i_clk  camera PCLK, rising edge
//   i_rst  asynchronous, active-high reset
//   bus    cam_capture_ds_if.slave: camera bus in, frame-buffer write port
//          and frame/clip/line-error status out
// -----------------------------------------------------------------------------
module cam_capture_ds #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15,
  parameter int DECIMATE      = 1
) (
  input logic             i_clk,
  input logic             i_rst,
  cam_capture_ds_if.slave bus
);

  localparam int                X_W = $clog2(SCREEN_WIDTH + 1);
  localparam logic [X_W-1:0]    W_X = X_W'(SCREEN_WIDTH);
  localparam logic [8:0]        H_Y = 9'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_LINE,
    BYTE_HI,
    BYTE_LO
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_prev_vsync;
  logic              r_prev_href;
  logic [1:0]        r_mode;
  logic [7:0]        r_b0;
  logic [9:0]        r_sx;
  logic [8:0]        r_sy;
  logic [X_W-1:0]    r_x;

  logic              r_w_en;
  logic [ADDR_W-1:0] r_w_addr;
  logic [7:0]        r_w_data;
  logic              r_frame_done;
  logic [7:0]        r_frame_count;
  logic              r_clip;
  logic              r_line_err;

  logic              w_vs_rise;
  logic              w_href_fall;
  logic              w_frame_start;
  logic              w_take_b0;
  logic              w_pixel;
  logic              w_line_end;
  logic              w_line_err_set;
  logic [8:0]        w_y;
  logic              w_storable;
  logic              w_in_bounds;
  logic [ADDR_W-1:0] w_addr_calc;

  function automatic logic [7:0] to_rgb332(input logic [1:0] mode,
                                           input logic [7:0] b0,
                                           input logic [7:0] b1);
    logic [7:0] px;
    case (mode)
      2'b00:   px = {b0[7:5], b0[2:0], b1[4:3]};          // RGB565
      2'b01:   px = {b0[6:4], b0[1:0], b1[7], b1[4:3]};   // RGB555
      2'b10:   px = {b0[3:1], b1[7:5], b1[3:2]};          // RGB444
      default: px = {b0[7:5], b0[7:5], b0[7:6]};          // YUV422, grey from Y
    endcase
    return px;
  endfunction

  assign w_vs_rise   = bus.vsync & ~r_prev_vsync;
  assign w_href_fall = ~bus.href & r_prev_href;

  // Stored line index; with decimation only even source lines survive.
  assign w_y         = (DECIMATE == 2) ? {1'b0, r_sy[8:1]} : r_sy;
  assign w_storable  = (DECIMATE == 1) || (!r_sx[0] && !r_sy[0]);
  assign w_in_bounds = (r_x < W_X) && (w_y < H_Y);
  // Only used when in bounds, so it never exceeds SCREEN_WIDTH*SCREEN_HEIGHT-1.
  assign w_addr_calc = ADDR_W'(w_y) * W_A + ADDR_W'(r_x);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: async reset in the sensitivity list; sequential state always uses <=
  // so every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= WAIT_FRAME;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and per-cycle control strobes. vs_rise outranks everything,
  // including a simultaneous href_fall.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_frame_start  = 1'b0;
    w_take_b0      = 1'b0;
    w_pixel        = 1'b0;
    w_line_end     = 1'b0;
    w_line_err_set = 1'b0;

    if (w_vs_rise) begin
      w_frame_start = 1'b1;
      w_state_nxt   = WAIT_LINE;
    end else begin
      case (r_state)
        WAIT_FRAME: ;
        WAIT_LINE: begin
          // The byte present on the edge HREF is first seen high is byte 0.
          if (bus.href) begin
            w_take_b0   = 1'b1;
            w_state_nxt = BYTE_LO;
          end
        end
        BYTE_HI: begin
          if (w_href_fall) begin
            w_line_end  = 1'b1;
            w_state_nxt = WAIT_LINE;
          end else begin
            w_take_b0   = 1'b1;
            w_state_nxt = BYTE_LO;
          end
        end
        BYTE_LO: begin
          if (w_href_fall) begin
            // A first byte is held with no partner: drop it and flag the line.
            w_line_end     = 1'b1;
            w_line_err_set = 1'b1;
            w_state_nxt    = WAIT_LINE;
          end else begin
            w_pixel     = 1'b1;
            w_state_nxt = BYTE_HI;
          end
        end
        default: w_state_nxt = WAIT_FRAME;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: edge detectors, pixel assembly, counters, write port, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev_vsync  <= 1'b0;
      r_prev_href   <= 1'b0;
      r_mode        <= 2'b00;
      r_b0          <= 8'h00;
      r_sx          <= '0;
      r_sy          <= '0;
      r_x           <= '0;
      r_w_en        <= 1'b0;
      r_w_addr      <= '0;
      r_w_data      <= 8'h00;
      r_frame_done  <= 1'b0;
      r_frame_count <= 8'h00;
      r_clip        <= 1'b0;
      r_line_err    <= 1'b0;
    end else begin
      r_prev_vsync <= bus.vsync;
      r_prev_href  <= bus.href;
      r_w_en       <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_frame_start) begin
        // A frame only counts as done if at least one line ended in it.
        if (r_state != WAIT_FRAME && r_sy != 9'd0) begin
          r_frame_done  <= 1'b1;
          r_frame_count <= r_frame_count + 8'd1;
        end
        r_mode     <= bus.mode;
        r_sx       <= '0;
        r_sy       <= '0;
        r_x        <= '0;
        r_clip     <= 1'b0;
        r_line_err <= 1'b0;
      end else begin
        if (w_take_b0) r_b0 <= bus.data;

        if (w_pixel) begin
          if (r_sx != 10'h3FF) r_sx <= r_sx + 10'd1;
          if (w_storable) begin
            if (w_in_bounds) begin
              r_w_en   <= 1'b1;
              r_w_addr <= w_addr_calc;
              r_w_data <= to_rgb332(r_mode, r_b0, bus.data);
              r_x      <= r_x + X_W'(1);
            end else begin
              // x only advances on a write, so it tops out at SCREEN_WIDTH.
              r_clip <= 1'b1;
            end
          end
        end

        if (w_line_end) begin
          r_sx <= '0;
          r_x  <= '0;
          if (r_sy != 9'h1FF) r_sy <= r_sy + 9'd1;
          if (w_line_err_set) r_line_err <= 1'b1;
        end
      end
    end
  end

  assign bus.w_en        = r_w_en;
  assign bus.w_addr      = r_w_addr;
  assign bus.w_data      = r_w_data;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_count = r_frame_count;
  assign bus.clip        = r_clip;
  assign bus.line_err    = r_line_err;

endmodule

// File: tb/tb_cam_capture_ds.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_ds
// Drives two capture instances from one camera stream: dut_a with the default
// 176x144 geometry and no decimation, dut_b with a 22x18 screen and 2:1
// decimation. A line-level reference model predicts every frame-buffer write
// and the frame/clip/line-error status.
// -----------------------------------------------------------------------------
module tb_cam_capture_ds;

  localparam int A_W  = 176;
  localparam int A_H  = 144;
  localparam int A_AW = 15;
  localparam int B_W  = 22;
  localparam int B_H  = 18;
  localparam int B_AW = 9;
  localparam int B_DEC = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       href_in;
  logic [7:0] data_in;
  logic [1:0] mode_in;

  always #5 clk = ~clk;

  cam_capture_ds_if #(.ADDR_W(A_AW)) bus_a ();
  cam_capture_ds_if #(.ADDR_W(B_AW)) bus_b ();

  assign bus_a.vsync = vsync_in;
  assign bus_a.href  = href_in;
  assign bus_a.data  = data_in;
  assign bus_a.mode  = mode_in;
  assign bus_b.vsync = vsync_in;
  assign bus_b.href  = href_in;
  assign bus_b.data  = data_in;
  assign bus_b.mode  = mode_in;

  cam_capture_ds #(
    .SCREEN_WIDTH(A_W), .SCREEN_HEIGHT(A_H), .ADDR_W(A_AW), .DECIMATE(1)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a)
  );

  cam_capture_ds #(
    .SCREEN_WIDTH(B_W), .SCREEN_HEIGHT(B_H), .ADDR_W(B_AW), .DECIMATE(B_DEC)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit   m_started;   // a vs_rise has been seen since reset
  int   m_lines;     // completed source lines this frame
  int   m_mode;      // format latched at the last vs_rise
  int   m_fcount;
  bit   m_clip[2];
  bit   m_lerr;
  wr_t  q_a[$];
  wr_t  q_b[$];

  int         last_addr_a, last_data_a, n_wr_a;
  int         last_addr_b, last_data_b, n_wr_b;

  function automatic logic [7:0] ref_rgb332(input int md, input logic [7:0] b0,
                                            input logic [7:0] b1);
    case (md)
      0:       return {b0[7:5], b0[2:0], b1[4:3]};
      1:       return {b0[6:4], b0[1:0], b1[7], b1[4:3]};
      2:       return {b0[3:1], b1[7:5], b1[3:2]};
      default: return {b0[7:5], b0[7:5], b0[7:6]};
    endcase
  endfunction

  // Predict the writes one source line produces in both instances.
  task automatic model_line(input bq_t bytes, input bit counted);
    int  npix, x, y, w, h, dec;
    wr_t e;
    if (!m_started) return;
    npix = bytes.size() / 2;
    for (int d = 0; d < 2; d++) begin
      w   = (d == 0) ? A_W : B_W;
      h   = (d == 0) ? A_H : B_H;
      dec = (d == 0) ? 1 : B_DEC;
      x   = 0;
      y   = m_lines / dec;
      for (int i = 0; i < npix; i++) begin
        if (dec == 1 || ((i % 2) == 0 && (m_lines % 2) == 0)) begin
          if (x < w && y < h) begin
            e.addr = y * w + x;
            e.data = int'(ref_rgb332(m_mode, bytes[2*i], bytes[2*i+1]));
            if (d == 0) q_a.push_back(e);
            else        q_b.push_back(e);
            x++;
          end else begin
            m_clip[d] = 1'b1;
          end
        end
      end
    end
    if (counted) begin
      if ((bytes.size() % 2) != 0) m_lerr = 1'b1;
      m_lines++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Write monitors: every strobe must match the head of the expected queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    wr_t e;
    if (bus_a.w_en === 1'b1) begin
      n_wr_a++;
      if (q_a.size() == 0) begin
        check("a_extra_wen_pending", 32'(q_a.size()), 32'd1);
      end else begin
        e = q_a.pop_front();
        check("a_waddr", 32'(bus_a.w_addr), e.addr);
        check("a_wdata", 32'(bus_a.w_data), e.data);
        last_addr_a = int'(bus_a.w_addr);
        last_data_a = int'(bus_a.w_data);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (bus_b.w_en === 1'b1) begin
      n_wr_b++;
      if (q_b.size() == 0) begin
        check("b_extra_wen_pending", 32'(q_b.size()), 32'd1);
      end else begin
        e = q_b.pop_front();
        check("b_waddr", 32'(bus_b.w_addr), e.addr);
        check("b_wdata", 32'(bus_b.w_data), e.data);
        last_addr_b = int'(bus_b.w_addr);
        last_data_b = int'(bus_b.w_data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Send one line; with tail=0 HREF is left high for frame_edge to drop.
  task automatic drive_line(input bq_t bytes, input bit tail);
    model_line(bytes, tail);
    foreach (bytes[i]) begin
      @(negedge clk);
      href_in = 1'b1;
      data_in = bytes[i];
    end
    if (tail) begin
      @(negedge clk);
      href_in = 1'b0;
      data_in = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // Raise VSYNC (optionally dropping HREF on the same edge) and check status.
  task automatic frame_edge(input bit with_hfall);
    bit exp_done;
    @(negedge clk);
    #1;
    check("a_clip_pre", 32'(bus_a.clip), 32'(m_clip[0]));
    check("b_clip_pre", 32'(bus_b.clip), 32'(m_clip[1]));
    check("a_lerr_pre", 32'(bus_a.line_err), 32'(m_lerr));
    check("b_lerr_pre", 32'(bus_b.line_err), 32'(m_lerr));
    check("a_pending", 32'(q_a.size()), 32'd0);
    check("b_pending", 32'(q_b.size()), 32'd0);
    q_a.delete();
    q_b.delete();
    exp_done = m_started && (m_lines > 0);
    if (exp_done) m_fcount = (m_fcount + 1) % 256;
    m_started = 1'b1;
    m_lines   = 0;
    m_clip[0] = 1'b0;
    m_clip[1] = 1'b0;
    m_lerr    = 1'b0;
    m_mode    = int'(mode_in);
    vsync_in  = 1'b1;
    if (with_hfall) href_in = 1'b0;
    @(negedge clk);
    #1;
    check("a_done", 32'(bus_a.frame_done), 32'(exp_done));
    check("b_done", 32'(bus_b.frame_done), 32'(exp_done));
    check("a_fcount", 32'(bus_a.frame_count), m_fcount);
    check("b_fcount", 32'(bus_b.frame_count), m_fcount);
    check("a_clip_clr", 32'(bus_a.clip), 32'd0);
    check("b_lerr_clr", 32'(bus_b.line_err), 32'd0);
    @(negedge clk);
    #1;
    check("a_done_pulse", 32'(bus_a.frame_done), 32'd0);
    vsync_in = 1'b0;
    href_in  = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_lines   = 0;
    m_mode    = 0;
    m_fcount  = 0;
    m_clip[0] = 1'b0;
    m_clip[1] = 1'b0;
    m_lerr    = 1'b0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bq_t  line;
    bq_t  keep;
    rst      = 1'b1;
    vsync_in = 1'b0;
    href_in  = 1'b0;
    data_in  = 8'h00;
    mode_in  = 2'b00;
    n_wr_a   = 0;
    n_wr_b   = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_wen", 32'(bus_a.w_en), 32'd0);
    check("rst_waddr", 32'(bus_a.w_addr), 32'd0);
    check("rst_wdata", 32'(bus_a.w_data), 32'd0);
    check("rst_done", 32'(bus_a.frame_done), 32'd0);
    check("rst_fcount", 32'(bus_a.frame_count), 32'd0);
    check("rst_clip", 32'(bus_a.clip), 32'd0);
    check("rst_lerr", 32'(bus_a.line_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bytes before the first vs_rise are ignored.
    drive_line(rand_bytes(10), 1'b1);
    frame_edge(1'b0);

    // RGB565 known line, then 5-byte line, then a normal line.
    line = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    drive_line(line, 1'b1);
    check("rgb565_last_addr", last_addr_a, 32'd1);
    check("rgb565_last_data", last_data_a, 32'h1C);
    drive_line(rand_bytes(5), 1'b1);
    check("lerr_set", 32'(bus_a.line_err), 32'(m_lerr));
    drive_line(rand_bytes(8), 1'b1);
    check("after_lerr_addr", last_addr_a, 2 * A_W + 3);
    frame_edge(1'b0);

    // MODE change mid-frame takes effect at the next vs_rise only.
    mode_in = 2'b11;
    line = '{8'hFF, 8'h00};
    drive_line(line, 1'b1);
    check("mode_old_fmt", last_data_a, 32'hFC);
    frame_edge(1'b0);
    drive_line(line, 1'b1);
    check("mode_yuv_a", last_data_a, 32'hFF);
    check("mode_yuv_b", last_data_b, 32'hFF);
    frame_edge(1'b0);

    // vs_rise together with href_fall on an odd line: no line, no FRAME_DONE.
    drive_line(rand_bytes(3), 1'b0);
    frame_edge(1'b1);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      mode_in = 2'($urandom_range(0, 3));
      frame_edge(1'b0);
      for (int l = 0; l < int'($urandom_range(1, 10)); l++)
        drive_line(rand_bytes(int'($urandom_range(1, 64))), 1'b1);
    end

    // Clipping in both dimensions: one 180-pixel line, 150 lines in total.
    mode_in = 2'($urandom_range(0, 3));
    frame_edge(1'b0);
    drive_line(rand_bytes(360), 1'b1);
    check("clip_w_a", 32'(bus_a.clip), 32'd1);
    for (int l = 1; l < 150; l++)
      drive_line(rand_bytes(int'($urandom_range(2, 8))), 1'b1);
    check("clip_pre_edge_a", 32'(bus_a.clip), 32'd1);
    frame_edge(1'b0);

    // Full decimated frame for dut_b: 44x36 source -> 22x18 stored.
    mode_in = 2'($urandom_range(0, 3));
    frame_edge(1'b0);
    n_wr_b = 0;
    for (int l = 0; l < 36; l++) begin
      line = rand_bytes(88);
      if (l == 34) keep = line;
      drive_line(line, 1'b1);
    end
    check("b_full_count", n_wr_b, B_W * B_H);
    check("b_full_last_addr", last_addr_b, B_W * B_H - 1);
    check("b_full_last_data", last_data_b,
          int'(ref_rgb332(m_mode, keep[84], keep[85])));
    frame_edge(1'b0);

    // Full 176x144 RGB565 frame of 0x00,0x1F.
    mode_in = 2'b00;
    frame_edge(1'b0);
    n_wr_a = 0;
    line = '{};
    for (int i = 0; i < A_W; i++) begin
      line.push_back(8'h00);
      line.push_back(8'h1F);
    end
    for (int l = 0; l < A_H; l++) drive_line(line, 1'b1);
    check("a_full_count", n_wr_a, A_W * A_H);
    check("a_full_last_addr", last_addr_a, A_W * A_H - 1);
    check("a_full_last_data", last_data_a, 32'h03);
    frame_edge(1'b0);

    // Reset mid-line while a write strobe is on the bus.
    line = '{8'($urandom), 8'($urandom)};
    model_line(line, 1'b0);
    @(negedge clk);
    href_in = 1'b1;
    data_in = line[0];
    @(negedge clk);
    data_in = line[1];
    @(negedge clk);
    data_in = 8'($urandom);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_wen_a", 32'(bus_a.w_en), 32'd0);
    check("rst_mid_wen_b", 32'(bus_b.w_en), 32'd0);
    check("rst_mid_fcount", 32'(bus_a.frame_count), 32'd0);
    check("rst_mid_waddr", 32'(bus_a.w_addr), 32'd0);
    check("rst_mid_wdata", 32'(bus_a.w_data), 32'd0);
    check("rst_mid_pending", 32'(q_a.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      data_in = 8'($urandom);
    end
    rst = 1'b0;
    n_wr_a = 0;
    drive_line(rand_bytes(12), 1'b1);
    check("no_write_before_vs", n_wr_a, 32'd0);
    frame_edge(1'b0);
    drive_line(rand_bytes(8), 1'b1);
    frame_edge(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
